// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bus between the multicycle LEGv8 main control FSM and its datapath.
//   opcode     : instruction[31:21] from the IR (datapath -> control)
//   mem_ready  : memory completes the current access (datapath -> control)
//   pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
//   reg2_loc, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, trap :
//                control -> datapath
//   retired    : retire counter, present only with MCU_PERF_CNT_EN defined
// Parameters: OPW opcode width; CNTW retire counter width (MCU_PERF_CNT_EN).
// Modports: master = control FSM side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int unsigned OPW = 11
`ifdef MCU_PERF_CNT_EN
  , parameter int unsigned CNTW = 32
`endif
);

  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic [1:0]     pc_source;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg2_loc;
  logic           mem_to_reg;
  logic           reg_write;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     alu_op;
  logic           trap;
`ifdef MCU_PERF_CNT_EN
  logic [CNTW-1:0] retired;
`endif

`ifdef MCU_PERF_CNT_EN
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg2_loc, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, trap, retired
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg2_loc, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, trap, retired
  );
`else
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg2_loc, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, trap
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
           ir_write, reg2_loc, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, trap
  );
`endif

endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Moore main control FSM for the multicycle LEGv8 datapath: fetch, decode,
// execute, memory and write-back sequencing, with memory-ready stalls and a
// sticky trap on unsupported opcodes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (returns to IDLE, outputs all 0)
//   bus   : multicycle_control_if.master (opcode/mem_ready in, controls out)
// Optional feature macro: MCU_PERF_CNT_EN adds the bus.retired counter.
// Outputs are a direct decode of the state register (FETCH also uses
// mem_ready), so they drop to 0 the instant rst_n falls.
// ---------------------------------------------------------------------------
module multicycle_control (
  input logic                  clk,
  input logic                  rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_TRAP      = 4'd11
  } state_t;

  state_t r_state;

  // Opcode class decode
  logic w_is_r, w_is_ldur, w_is_stur, w_is_cbz, w_is_b;

  assign w_is_r    = (bus.opcode == 11'b10001011000) ||
                     (bus.opcode == 11'b11001011000) ||
                     (bus.opcode == 11'b10001010000) ||
                     (bus.opcode == 11'b10101010000);
  assign w_is_ldur = (bus.opcode == 11'b11111000010);
  assign w_is_stur = (bus.opcode == 11'b11111000000);
  assign w_is_cbz  = (bus.opcode[10:3] == 8'b10110100);
  assign w_is_b    = (bus.opcode[10:5] == 6'b000101);

  // State register with next-state logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      r_state <= ST_FETCH;
        ST_FETCH:     if (bus.mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_is_r)                      r_state <= ST_EXECUTE;
          else if (w_is_ldur || w_is_stur) r_state <= ST_MEM_ADDR;
          else if (w_is_cbz)               r_state <= ST_BRANCH;
          else if (w_is_b)                 r_state <= ST_JUMP;
          else                             r_state <= ST_TRAP;
        end
        // Opcode is re-checked here; anything but a load/store traps
        ST_MEM_ADDR: begin
          if (w_is_ldur)      r_state <= ST_MEM_READ;
          else if (w_is_stur) r_state <= ST_MEM_WRITE;
          else                r_state <= ST_TRAP;
        end
        ST_MEM_READ:  if (bus.mem_ready) r_state <= ST_MEM_WB;
        ST_MEM_WB:    r_state <= ST_FETCH;
        ST_MEM_WRITE: if (bus.mem_ready) r_state <= ST_FETCH;
        ST_EXECUTE:   r_state <= ST_R_WB;
        ST_R_WB:      r_state <= ST_FETCH;
        ST_BRANCH:    r_state <= ST_FETCH;
        ST_JUMP:      r_state <= ST_FETCH;
        ST_TRAP:      r_state <= ST_TRAP;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_source     = 2'b00;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg2_loc      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.trap          = 1'b0;
    case (r_state)
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC update only on the cycle the fetch completes
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      ST_DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.reg2_loc  = w_is_stur || w_is_cbz;
      end
      ST_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.reg2_loc  = 1'b1;
      end
      ST_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        bus.reg2_loc  = 1'b1;
      end
      ST_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      ST_R_WB: begin
        bus.reg_write = 1'b1;
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.reg2_loc      = 1'b1;
      end
      ST_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
      ST_TRAP: begin
        bus.trap = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef MCU_PERF_CNT_EN
  localparam int unsigned CNTW = $bits(bus.retired);

  logic            w_retire;
  logic [CNTW-1:0] r_retired;

  // An instruction retires when its last state hands back to FETCH
  assign w_retire = (r_state == ST_MEM_WB) ||
                    ((r_state == ST_MEM_WRITE) && bus.mem_ready) ||
                    (r_state == ST_R_WB) ||
                    (r_state == ST_BRANCH) ||
                    (r_state == ST_JUMP);

  // Retire counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + CNTW'(1);
  end

  assign bus.retired = r_retired;
`endif

endmodule
